// File: rtl/cim_xbar_tile.sv
// One CIM crossbar tile: input/weight buffers, row-serial MVM into wide accumulators, registered readout.
// Define CIM_XBAR_SATURATE_EN to saturate results on narrowing instead of wrapping.
module cim_xbar_tile #(
   parameter int xbar_size     = 256,
   parameter int datatype_size = 8,
   parameter int acc_shift     = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_we,
   input  logic [$clog2(xbar_size)-1:0] i_wr_addr,
   input  logic [datatype_size-1:0]     i_wr_data,
   input  logic                         i_start,
   output logic                         o_busy,
   input  logic [$clog2(xbar_size)-1:0] i_rd_addr,
   output logic [datatype_size-1:0]     o_rd_data,
   input  logic                         i_w_we,
   input  logic [$clog2(xbar_size)-1:0] i_w_row,
   input  logic [$clog2(xbar_size)-1:0] i_w_col,
   input  logic [datatype_size-1:0]     i_w_data
);

   localparam int AW        = $clog2(xbar_size);
   localparam int DW        = datatype_size;
   localparam int ACC_W     = 2*datatype_size + $clog2(xbar_size);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COMPUTE = 2'd1;
   localparam logic [1:0] ST_WB      = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [AW-1:0]    row_q, row_d;
   logic [ACC_W-1:0] acc_q  [xbar_size];
   logic [ACC_W-1:0] acc_d  [xbar_size];
   logic [DW-1:0]    obuf_q [xbar_size];
   logic [DW-1:0]    obuf_d [xbar_size];
   logic [DW-1:0]    rd_data_q, rd_data_d;
   logic [DW-1:0]    ibuf_mem [xbar_size];
   logic [DW-1:0]    w_mem    [xbar_size][xbar_size];
   logic             idle;

   function automatic logic [ACC_W-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [2*DW-1:0] prod;
      prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      return {{(ACC_W-2*DW){1'b0}}, prod};
   endfunction

   function automatic logic [DW-1:0] narrow(input logic [ACC_W-1:0] acc);
      logic [ACC_W-1:0] shifted;
      shifted = acc >> acc_shift;
`ifdef CIM_XBAR_SATURATE_EN
      return (shifted > {{(ACC_W-DW){1'b0}}, {DW{1'b1}}}) ? {DW{1'b1}} : DW'(shifted);
`else
      return DW'(shifted);
`endif
   endfunction

   assign idle      = (state_q == ST_IDLE);
   assign o_busy    = !idle;
   assign o_rd_data = rd_data_q;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d   = state_q;
      row_d     = row_q;
      acc_d     = acc_q;
      obuf_d    = obuf_q;
      rd_data_d = obuf_q[i_rd_addr];
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d = ST_COMPUTE;
               row_d   = '0;
               acc_d   = '{default: '0};
            end
         end
         ST_COMPUTE: begin
            // One crossbar row per cycle, all columns in parallel.
            for (int c = 0; c < xbar_size; c++) begin
               acc_d[c] = acc_q[c] + mul_ext(ibuf_mem[row_q], w_mem[row_q][c]);
            end
            row_d = row_q + AW'(1);
            if (row_q == AW'(xbar_size-1)) state_d = ST_WB;
         end
         ST_WB: begin
            for (int c = 0; c < xbar_size; c++) begin
               obuf_d[c] = narrow(acc_q[c]);
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         row_q     <= '0;
         acc_q     <= '{default: '0};
         obuf_q    <= '{default: '0};
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         acc_q     <= acc_d;
         obuf_q    <= obuf_d;
         rd_data_q <= rd_data_d;
      end
   end

   // NOTE: input buffer and weights are plain memories with no reset, so they survive an abort.
   always_ff @(posedge clk) begin
      if (idle && i_we)   ibuf_mem[i_wr_addr]      <= i_wr_data;
      if (idle && i_w_we) w_mem[i_w_row][i_w_col] <= i_w_data;
   end

endmodule

// File: doc/cim_xbar_tile.md
Name: cim_xbar_tile

Overview:
Cycle-level behavioural model of one CIM crossbar tile: the responder side of the fc layer's CIM interface.
- Accepts input-vector writes from the layer controller and computes a matrix-vector multiply against stored weights.
- Holds busy while computing.
- Serves results through a registered output buffer, read by the layer's activation/func stage.
- Used in simulation and as a synthesizable stand-in until the analog macro wrapper exists.

Parameters:
xbar_size, 256, crossbar rows = columns; input-vector length and output-vector length.
datatype_size, 8, width of input elements, weights and output elements (unsigned).
acc_shift, 0, right-shift applied to each accumulator before narrowing to datatype_size.
acc_width, 2*datatype_size+$clog2(xbar_size), accumulator width (derived, do not override).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_we  in  1  input-buffer write enable (from layer ctrl)
i_wr_addr  in  $clog2(xbar_size)  input-buffer row address
i_wr_data  in  datatype_size  input element
i_start  in  1  start MVM
o_busy  out  1  tile busy (ctrl and func both observe it)
i_rd_addr  in  $clog2(xbar_size)  output-buffer column address
o_rd_data  out  datatype_size  output element, registered
i_w_we  in  1  weight programming write enable
i_w_row  in  $clog2(xbar_size)  weight row
i_w_col  in  $clog2(xbar_size)  weight column
i_w_data  in  datatype_size  weight value

Behaviour:
- Reset values: o_busy=0, o_rd_data=0, state=IDLE, row counter=0, accumulators=0, output buffer=0.
  - Input buffer and weight array are not cleared; they are memories.
- Storage:
  - ibuf[xbar_size]
  - W[xbar_size][xbar_size], indexed [row][col]
  - acc[xbar_size], acc_width each
  - obuf[xbar_size], datatype_size each
- Writes:
  - i_we in IDLE writes ibuf[i_wr_addr] at the clock edge.
  - i_w_we in IDLE writes W[i_w_row][i_w_col].
  - Both writes in IDLE are ignored while o_busy=1 (no effect, no error).
  - i_we and i_w_we in the same IDLE cycle are both performed.
- FSM states: IDLE, COMPUTE, WB.
  - IDLE: i_start=1 -> clear all acc, row=0, go to COMPUTE, o_busy=1 from the next cycle. If i_we and i_start coincide, the write lands first and is used by the compute.
  - COMPUTE: each cycle, for every col, acc[col] += ibuf[row]*W[row][col]; row++. After row=xbar_size-1 is processed, go to WB. Lasts exactly xbar_size cycles.
  - WB: obuf[col] = narrow(acc[col] >> acc_shift) for all col; go to IDLE; o_busy=0 from the next cycle.
- Timing: i_start sampled at edge T -> o_busy high for xbar_size+1 cycles, from edge T through edge T+xbar_size+1, low after it.
- i_start while o_busy=1 is ignored; no queueing.
- Read port:
  - o_rd_data <= obuf[i_rd_addr] every cycle; 1-cycle latency, independent of state.
  - Reads during COMPUTE return the previous result (obuf is only updated in WB).
  - A read addressed in the WB cycle returns the old value; the new value is returned from the cycle after.
- Arithmetic:
  - Unsigned multiply, 2*datatype_size bits.
  - Accumulation in acc_width bits, which cannot overflow.
  - narrow() is defined under Optional Feature.
- Reset mid-operation: abort immediately; state=IDLE, o_busy=0, obuf=0, acc=0. The next i_start recomputes from scratch.

Optional Feature:
Macro CIM_XBAR_SATURATE_EN.
- Defined: narrow(x) = x > 2^datatype_size-1 ? 2^datatype_size-1 : x[datatype_size-1:0].
- Undefined: narrow(x) = x[datatype_size-1:0] (wrap/truncate).

Test Plan:
(All scenarios use xbar_size=4, datatype_size=8, acc_shift=0.)
1. Identity MVM: W=identity; ibuf={3,5,7,9}; start -> o_busy high exactly 5 cycles; reads col0..3 (1-cycle latency) -> {3,5,7,9}.
2. Full matrix: W[r][c]=r+c+1; ibuf={1,2,3,4} -> obuf={30,40,50,60}.
3. Overflow: W all 255, ibuf all 255 -> acc=260100 per column; with CIM_XBAR_SATURATE_EN obuf=255; without it obuf=260100 mod 256=4.
4. Busy protection: during COMPUTE issue i_we to addr0 value 99, i_w_we, and i_start -> results match the pre-busy data; ibuf[0] and W unchanged; one compute only (busy drops after 5 cycles, stays low). Reads during COMPUTE return the previous obuf.
5. Reset mid-compute: assert rst on the 2nd COMPUTE cycle -> next cycle o_busy=0, o_rd_data=0, all obuf reads 0. Restart start -> correct result from retained ibuf/W.
6. Back-to-back: start again in the first IDLE cycle after busy falls, with ibuf[0] rewritten in the same cycle -> second result uses the new value; first result remains readable throughout the second COMPUTE.
